// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/exception controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    NPC_NORMAL  = 2'd0,
    NPC_HANDLER = 2'd1,
    NPC_EPC     = 2'd2
  } npc_sel_t;

  localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-side control bundle: hazard/exception inputs and stall/redirect outputs.
interface pipe_ctrl_if;
  logic        D_data_hazard;
  logic        D_use_md;
  logic        E_md_start;
  logic        E_md_is_div;
  logic        M_exc_req;
  logic        M_is_eret;
  logic [31:0] EPC;
  logic        stall;
  logic        Req;
  logic        eret_flush;
  logic [1:0]  npc_sel;
  logic [31:0] npc;
  logic        md_busy;

  modport master (
    output D_data_hazard, D_use_md, E_md_start, E_md_is_div, M_exc_req, M_is_eret, EPC,
    input  stall, Req, eret_flush, npc_sel, npc, md_busy
  );

  modport slave (
    input  D_data_hazard, D_use_md, E_md_start, E_md_is_div, M_exc_req, M_is_eret, EPC,
    output stall, Req, eret_flush, npc_sel, npc, md_busy
  );
endinterface

// File: rtl/pipe_ctrl_md_busy_counter.sv
// Mult/div occupancy counter: loads on issue when idle, counts down to zero.
module md_busy_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam int unsigned CW = $clog2(max_u(MULT_CYCLES, DIV_CYCLES) + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end else if (start) begin
      cnt <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall / exception-redirect controller.
// Define PIPE_CTRL_MD_EN to enable the mult/div busy counter and its stall term.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter logic [31:0] HANDLER_PC  = HANDLER_PC_DEFAULT
) (
  input logic        clk,
  input logic        reset,
  pipe_ctrl_if.slave pif
);

  state_t   state, state_nxt;
  npc_sel_t sel;
  logic     req;
  logic     eret_fl;
  logic     md_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // Outputs are gated by reset so they read zero while reset is held, whatever the inputs.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    eret_fl   = 1'b0;
    sel       = NPC_NORMAL;
    case (state)
      RUN: begin
        if (pif.M_exc_req) begin
          req       = 1'b1;
          sel       = NPC_HANDLER;
          state_nxt = HOLD;
        end else if (pif.M_is_eret) begin
          eret_fl = 1'b1;
          sel     = NPC_EPC;
        end
      end
      HOLD:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    if (!reset) begin
      req     = 1'b0;
      eret_fl = 1'b0;
      sel     = NPC_NORMAL;
    end
  end

  always_comb begin
    case (sel)
      NPC_HANDLER: pif.npc = HANDLER_PC;
      NPC_EPC:     pif.npc = pif.EPC;
      default:     pif.npc = '0;
    endcase
  end

`ifdef PIPE_CTRL_MD_EN
  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .start  (pif.E_md_start & ~req),
    .is_div (pif.E_md_is_div),
    .busy   (md_busy)
  );

  assign pif.stall = reset & ~req &
                     (pif.D_data_hazard | (pif.D_use_md & (md_busy | pif.E_md_start)));
`else
  logic unused_md;
  assign unused_md = pif.E_md_start ^ pif.E_md_is_div ^ pif.D_use_md;
  assign md_busy   = 1'b0;
  assign pif.stall = reset & ~req & pif.D_data_hazard;
`endif

  assign pif.Req        = req;
  assign pif.eret_flush = eret_fl;
  assign pif.npc_sel    = sel;
  assign pif.md_busy    = md_busy;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam logic [31:0] HPC = 32'h0000_4180;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  pipe_ctrl_if pif ();

  pipe_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .HANDLER_PC  (HPC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .pif   (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: whether the previous cycle took an exception, and mult/div cycles left.
  bit m_after_exc;
  int m_md_left;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit haz, input bit use_md, input bit start, input bit is_div,
                      input bit exc, input bit eret, input logic [31:0] epc, input bit rst_n);
    bit          exc_taken, eret_taken, busy, exp_stall;
    logic [31:0] exp_npc;
    logic [31:0] exp_sel;
    bit          nxt_after;
    int          nxt_left;

    @(negedge clk);
    pif.D_data_hazard = haz;
    pif.D_use_md      = use_md;
    pif.E_md_start    = start;
    pif.E_md_is_div   = is_div;
    pif.M_exc_req     = exc;
    pif.M_is_eret     = eret;
    pif.EPC           = epc;
    reset             = rst_n;
    if (!rst_n) begin
      m_after_exc = 1'b0;
      m_md_left   = 0;
    end
    #1;

    exc_taken  = rst_n && !m_after_exc && exc;
    eret_taken = rst_n && !m_after_exc && !exc && eret;
    exp_sel    = exc_taken ? 32'd1 : (eret_taken ? 32'd2 : 32'd0);
    exp_npc    = exc_taken ? HPC : (eret_taken ? epc : 32'd0);
`ifdef PIPE_CTRL_MD_EN
    busy      = (m_md_left > 0);
    exp_stall = rst_n && !exc_taken && (haz || (use_md && (busy || start)));
`else
    busy      = 1'b0;
    exp_stall = rst_n && !exc_taken && haz;
`endif

    check("Req",        32'(pif.Req),        32'(exc_taken));
    check("eret_flush", 32'(pif.eret_flush), 32'(eret_taken));
    check("npc_sel",    32'(pif.npc_sel),    exp_sel);
    check("npc",        pif.npc,             exp_npc);
    check("stall",      32'(pif.stall),      32'(exp_stall));
    check("md_busy",    32'(pif.md_busy),    32'(busy));

    nxt_after = exc_taken;
    nxt_left  = m_md_left;
    if (!rst_n)                      nxt_left = 0;
    else if (m_md_left > 0)          nxt_left = m_md_left - 1;
    else if (start && !exc_taken)    nxt_left = is_div ? 10 : 5;
`ifndef PIPE_CTRL_MD_EN
    nxt_left = 0;
`endif
    @(posedge clk);
    m_after_exc = nxt_after;
    m_md_left   = nxt_left;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 32'h0, 1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_after_exc = 1'b0;
    m_md_left   = 0;
    pif.D_data_hazard = 1'b0;
    pif.D_use_md      = 1'b0;
    pif.E_md_start    = 1'b0;
    pif.E_md_is_div   = 1'b0;
    pif.M_exc_req     = 1'b0;
    pif.M_is_eret     = 1'b0;
    pif.EPC           = '0;
    reset = 1'b1;
    #2 reset = 1'b0;

    // Reset state with every input active.
    step(1, 1, 1, 1, 1, 1, 32'hDEAD_BEEF, 0);
    step(1, 1, 1, 0, 1, 0, 32'h1234_5678, 0);
    idle(2);

    // Exception entry, then a second request swallowed by the drain cycle.
    step(0, 0, 0, 0, 1, 0, 32'h0, 1);
    step(0, 0, 0, 0, 1, 1, 32'h0000_2000, 1);
    idle(1);

    // eret redirect.
    step(0, 0, 0, 0, 0, 1, 32'h0000_3010, 1);
    idle(1);

    // Divide occupancy with a dependent D instruction.
    step(0, 1, 1, 1, 0, 0, 32'h0, 1);
    for (int i = 0; i < 11; i++) step(0, 1, 0, 0, 0, 0, 32'h0, 1);

    // Everything at once: exception wins, no issue, no stall.
    step(1, 1, 1, 1, 1, 1, 32'h0000_5000, 1);
    step(0, 0, 0, 0, 0, 0, 32'h0, 1);
    idle(1);

    // Exception while a multiply is already running must not cancel it.
    step(0, 0, 1, 0, 0, 0, 32'h0, 1);
    step(0, 1, 0, 0, 1, 0, 32'h0, 1);
    step(0, 1, 1, 1, 0, 0, 32'h0, 1);
    idle(6);

    // Reset in the middle of a multiply.
    step(0, 0, 1, 0, 0, 0, 32'h0, 1);
    idle(2);
    step(0, 1, 0, 0, 0, 0, 32'h0, 0);
    step(0, 1, 1, 0, 1, 1, 32'h0000_6000, 0);
    idle(3);

    // Hazard alone with the unit requested but idle.
    step(1, 0, 0, 0, 0, 0, 32'h0, 1);
    step(0, 0, 1, 0, 0, 0, 32'h0, 1);
    idle(6);

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
           $urandom, $urandom_range(0, 49) != 0);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
- REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult/multu.
- REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu.
- REQ-003 SHALL have parameter HANDLER_PC, default 32'h0000_4180, exception entry address.
- REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
- REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
- REQ-006 SHALL have port D_data_hazard  in  1  GPR read-after-write hazard flag from the D-stage comparator.
- REQ-007 SHALL have port D_use_md  in  1  D instruction is mult/div or reads/writes HI/LO.
- REQ-008 SHALL have port E_md_start  in  1  E-stage mult/div issue pulse.
- REQ-009 SHALL have port E_md_is_div  in  1  issued op is div/divu (selects DIV_CYCLES).
- REQ-010 SHALL have port M_exc_req  in  1  exception/interrupt taken in M stage.
- REQ-011 SHALL have port M_is_eret  in  1  eret in M stage.
- REQ-012 SHALL have port EPC  in  32  return address for eret.
- REQ-013 SHALL have port stall  out  1  freezes PC and FD, bubbles DE.
- REQ-014 SHALL have port Req  out  1  flushes all pipeline registers; FD loads HANDLER_PC.
- REQ-015 SHALL have port eret_flush  out  1  clears FD only.
- REQ-016 SHALL have port npc_sel  out  2  0 normal, 1 HANDLER_PC, 2 EPC.
- REQ-017 SHALL have port npc  out  32  redirect target, valid when npc_sel != 0.
- REQ-018 SHALL have port md_busy  out  1  mult/div unit occupied.

Function
- REQ-019 SHALL implement a 2-state FSM: RUN, HOLD.
- REQ-020 SHALL in RUN assert Req combinationally in the same cycle as M_exc_req; next state HOLD.
- REQ-021 SHALL in HOLD keep Req=0, ignore M_exc_req and M_is_eret for exactly one cycle (bubble drain), then return to RUN.
- REQ-022 SHALL in RUN assert eret_flush=1 and npc_sel=2, npc=EPC combinationally on M_is_eret with M_exc_req=0; state stays RUN.
- REQ-023 SHALL give M_exc_req priority over M_is_eret in the same cycle (npc_sel=1, eret_flush=0).
- REQ-024 SHALL drive npc=HANDLER_PC when npc_sel=1, and npc=0 when npc_sel=0.
- REQ-025 SHALL compute stall = (D_data_hazard | (D_use_md & (md_busy | E_md_start))) & ~Req.
- REQ-026 SHALL load the md counter with MULT_CYCLES or DIV_CYCLES on E_md_start & ~Req & ~md_busy; Req suppresses issue because the E instruction is flushed.
- REQ-027 SHALL decrement the counter by 1 per cycle while nonzero, and drive md_busy = (counter != 0).
- REQ-028 SHALL ignore E_md_start while md_busy; the counter is not reloaded.
- REQ-029 SHALL NOT let Req cancel a counter that is already running; that op belongs to an older, committed instruction.
- REQ-030 SHALL size the counter to hold max(MULT_CYCLES, DIV_CYCLES), with no wrap below 0.

Reset
- REQ-031 SHALL, while reset=0 and asynchronously, set the FSM to RUN and the counter to 0.
- REQ-032 SHALL during reset drive Req, eret_flush, stall, md_busy=0, npc_sel=0, npc=0, regardless of inputs.
- REQ-033 SHALL, on reset release mid-operation, never resume any busy or HOLD state.

Configuration
- REQ-034 SHALL, with macro PIPE_CTRL_MD_EN defined, instantiate the mult/div counter per REQ-026..030.
- REQ-035 SHALL, without PIPE_CTRL_MD_EN, tie md_busy=0, make stall = D_data_hazard & ~Req, and ignore E_md_start, E_md_is_div and D_use_md.

Structure
- REQ-036 SHALL place the FSM state typedef (RUN, HOLD), npc_sel encodings and the HANDLER_PC default in package pipe_ctrl_pkg.
- REQ-037 SHALL implement the counter as sub-module md_busy_counter, compiled only under PIPE_CTRL_MD_EN.

Verification
- REQ-038 SHALL cover exception entry: M_exc_req=1 for 1 cycle -> Req=1 and npc=32'h0000_4180 that cycle; Req=0 next cycle, with M_exc_req=1 ignored in HOLD.
- REQ-039 SHALL cover eret: M_is_eret=1, EPC=32'h0000_3010 -> eret_flush=1, npc_sel=2, npc=32'h0000_3010, Req=0.
- REQ-040 SHALL cover div busy: E_md_start=1, E_md_is_div=1 -> md_busy=1 for 10 cycles; D_use_md=1 gives stall=1 for those 10 cycles plus the issue cycle.
- REQ-041 SHALL cover simultaneous events: M_exc_req=1, M_is_eret=1, E_md_start=1, D_data_hazard=1 -> Req=1, npc_sel=1, stall=0, counter stays 0.
- REQ-042 SHALL cover mid-mult reset: reset=0 at count 3 -> md_busy=0 immediately; after release, state=RUN and all outputs 0.
- REQ-043 SHALL cover the macro-off build: E_md_start=1 -> md_busy stays 0, and stall follows D_data_hazard only.
